ram_2p_arb: RTL and testbench

Four-requester arbiter and sequencer for the dual-port RAM model (`ram_2p`, active-low enables, 1-cycle read latency). Each cycle it grants up to two requesters and maps them onto RAM ports A and B. It drives the RAM's chip, write and output enables, address and write data from registered outputs. It routes read data back to the owning requester with a valid strobe. It sits between the encoder-side buffer clients (e.g. fetch, IME, MC readers, reconstruction writer) and a shared `ram_2p` instance.

---
 rtl/ram_2p_arb.sv | 165 ++++++++++++++++
 tb/tb_ram_2p_arb.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_2p_arb.sv
// Four-requester arbiter/sequencer in front of a dual-port ram_2p (active-low enables, 1-cycle read).
// Define RAM_ARB_RR_EN for round-robin selection; otherwise requester 0 has fixed highest priority.
module ram_2p_arb #(
    parameter int WORD_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [3:0]              req_i,
    input  logic [3:0]              we_i,
    input  logic [4*ADDR_WIDTH-1:0] addr_i,
    input  logic [4*WORD_WIDTH-1:0] wdata_i,
    output logic [3:0]              gnt_o,
    output logic [3:0]              rvalid_o,
    output logic [4*WORD_WIDTH-1:0] rdata_o,
    output logic                    ram_cena_o,
    output logic                    ram_cenb_o,
    output logic                    ram_wena_o,
    output logic                    ram_wenb_o,
    output logic                    ram_oena_o,
    output logic                    ram_oenb_o,
    output logic [ADDR_WIDTH-1:0]   ram_addra_o,
    output logic [ADDR_WIDTH-1:0]   ram_addrb_o,
    output logic [WORD_WIDTH-1:0]   ram_dataa_o,
    output logic [WORD_WIDTH-1:0]   ram_datab_o,
    input  logic [WORD_WIDTH-1:0]   ram_dataa_i,
    input  logic [WORD_WIDTH-1:0]   ram_datab_i
);

    logic [ADDR_WIDTH-1:0] req_addr [4];
    logic [WORD_WIDTH-1:0] req_wdata [4];
    logic [1:0]            rot_idx [4];
    logic [1:0]            ptr;

    logic                  found_a, found_b, conflict;
    logic [1:0]            idx_a, idx_b;
    logic                  port_gnt [2];
    logic [1:0]            port_idx [2];
    logic [WORD_WIDTH-1:0] ram_rdata [2];

    logic                  cen_reg [2];
    logic                  wen_reg [2];
    logic [ADDR_WIDTH-1:0] addr_reg [2];
    logic [WORD_WIDTH-1:0] data_reg [2];
    logic                  tag1_valid_reg [2];
    logic [1:0]            tag1_id_reg [2];
    logic                  tag2_valid_reg [2];
    logic [1:0]            tag2_id_reg [2];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_unpack
            assign req_addr[gi]  = addr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign req_wdata[gi] = wdata_i[gi*WORD_WIDTH +: WORD_WIDTH];
            assign rot_idx[gi]   = ptr + 2'(gi);
        end
    endgenerate

`ifdef RAM_ARB_RR_EN
    logic [1:0] ptr_reg;

    // Resume scanning just past the last requester served.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_reg <= 2'd0;
        end else if (port_gnt[1]) begin
            ptr_reg <= port_idx[1] + 2'd1;
        end else if (port_gnt[0]) begin
            ptr_reg <= port_idx[0] + 2'd1;
        end
    end

    assign ptr = ptr_reg;
`else
    assign ptr = 2'd0;
`endif

    always_comb begin
        found_a = 1'b0;
        found_b = 1'b0;
        idx_a   = 2'd0;
        idx_b   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (req_i[rot_idx[i]]) begin
                if (!found_a) begin
                    found_a = 1'b1;
                    idx_a   = rot_idx[i];
                end else if (!found_b) begin
                    found_b = 1'b1;
                    idx_b   = rot_idx[i];
                end
            end
        end
    end

    // Same-address pair with any write: port B backs off so ordering stays defined.
    assign conflict = found_a && found_b && (req_addr[idx_a] == req_addr[idx_b])
                      && (we_i[idx_a] || we_i[idx_b]);

    assign port_gnt[0] = found_a && !rst;
    assign port_gnt[1] = found_b && !conflict && !rst;
    assign port_idx[0] = idx_a;
    assign port_idx[1] = idx_b;
    assign ram_rdata[0] = ram_dataa_i;
    assign ram_rdata[1] = ram_datab_i;

    always_comb begin
        gnt_o = 4'b0000;
        for (int p = 0; p < 2; p++) begin
            if (port_gnt[p]) begin
                gnt_o[port_idx[p]] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int p = 0; p < 2; p++) begin
            if (rst) begin
                cen_reg[p]        <= 1'b1;
                wen_reg[p]        <= 1'b1;
                addr_reg[p]       <= '0;
                data_reg[p]       <= '0;
                tag1_valid_reg[p] <= 1'b0;
                tag1_id_reg[p]    <= 2'd0;
                tag2_valid_reg[p] <= 1'b0;
                tag2_id_reg[p]    <= 2'd0;
            end else begin
                cen_reg[p] <= ~port_gnt[p];
                wen_reg[p] <= port_gnt[p] ? ~we_i[port_idx[p]] : 1'b1;
                if (port_gnt[p]) begin
                    addr_reg[p] <= req_addr[port_idx[p]];
                    data_reg[p] <= req_wdata[port_idx[p]];
                end
                tag1_valid_reg[p] <= port_gnt[p] && !we_i[port_idx[p]];
                tag1_id_reg[p]    <= port_idx[p];
                tag2_valid_reg[p] <= tag1_valid_reg[p];
                tag2_id_reg[p]    <= tag1_id_reg[p];
            end
        end
    end

    // A requester never holds both ports in one cycle, so the two returns never collide.
    always_comb begin
        rvalid_o = 4'b0000;
        rdata_o  = '0;
        for (int p = 0; p < 2; p++) begin
            if (tag2_valid_reg[p]) begin
                rvalid_o[tag2_id_reg[p]] = 1'b1;
                rdata_o[tag2_id_reg[p]*WORD_WIDTH +: WORD_WIDTH] = ram_rdata[p];
            end
        end
    end

    assign ram_cena_o  = cen_reg[0];
    assign ram_cenb_o  = cen_reg[1];
    assign ram_wena_o  = wen_reg[0];
    assign ram_wenb_o  = wen_reg[1];
    assign ram_oena_o  = 1'b0;
    assign ram_oenb_o  = 1'b0;
    assign ram_addra_o = addr_reg[0];
    assign ram_addrb_o = addr_reg[1];
    assign ram_dataa_o = data_reg[0];
    assign ram_datab_o = data_reg[1];

endmodule

// File: tb/tb_ram_2p_arb.sv
// Directed bench for ram_2p_arb with a behavioural dual-port RAM (1-cycle read, active-low enables).
module tb_ram_2p_arb;

    logic        clk;
    logic        rst;
    logic [3:0]  req_i, we_i;
    logic [31:0] addr_i;
    logic [127:0] wdata_i;
    logic [3:0]  gnt_o, rvalid_o;
    logic [127:0] rdata_o;
    logic        ram_cena_o, ram_cenb_o, ram_wena_o, ram_wenb_o, ram_oena_o, ram_oenb_o;
    logic [7:0]  ram_addra_o, ram_addrb_o;
    logic [31:0] ram_dataa_o, ram_datab_o, ram_dataa_i, ram_datab_i;

    int n_cmp = 0;
    int n_err = 0;

    ram_2p_arb dut (
        .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .gnt_o(gnt_o), .rvalid_o(rvalid_o), .rdata_o(rdata_o),
        .ram_cena_o(ram_cena_o), .ram_cenb_o(ram_cenb_o),
        .ram_wena_o(ram_wena_o), .ram_wenb_o(ram_wenb_o),
        .ram_oena_o(ram_oena_o), .ram_oenb_o(ram_oenb_o),
        .ram_addra_o(ram_addra_o), .ram_addrb_o(ram_addrb_o),
        .ram_dataa_o(ram_dataa_o), .ram_datab_o(ram_datab_o),
        .ram_dataa_i(ram_dataa_i), .ram_datab_i(ram_datab_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model
    logic [31:0] mem [256];
    logic [31:0] qa, qb;
    always @(posedge clk) begin
        if (!ram_cena_o) begin
            if (!ram_wena_o) mem[ram_addra_o] <= ram_dataa_o;
            else             qa <= mem[ram_addra_o];
        end
        if (!ram_cenb_o) begin
            if (!ram_wenb_o) mem[ram_addrb_o] <= ram_datab_o;
            else             qb <= mem[ram_addrb_o];
        end
    end
    assign ram_dataa_i = qa;
    assign ram_datab_i = qb;

    typedef struct {
        logic [3:0] req;
        logic [3:0] we;
        logic [7:0] a0, a1, a2, a3;
        logic [3:0] gnt;
        logic       cena, cenb, wena, wenb;
        logic [7:0] addra, addrb;
    } vec_t;

    vec_t vecs [8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        req_i   = 4'b0000;
        we_i    = 4'b0000;
        addr_i  = '0;
        wdata_i = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle_inputs();
        step();
        rst = 1'b0;
    endtask

    logic [3:0] fair_exp [6];

    initial begin
        vecs[0] = '{4'b0000, 4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b1, 8'h00, 8'h00};
        vecs[1] = '{4'b0001, 4'b0000, 8'h11, 8'h00, 8'h00, 8'h00, 4'b0001, 1'b0, 1'b1, 1'b1, 1'b1, 8'h11, 8'h00};
        vecs[2] = '{4'b1000, 4'b1000, 8'h00, 8'h00, 8'h00, 8'h44, 4'b1000, 1'b0, 1'b1, 1'b0, 1'b1, 8'h44, 8'h00};
        vecs[3] = '{4'b0110, 4'b0000, 8'h00, 8'h21, 8'h22, 8'h00, 4'b0110, 1'b0, 1'b0, 1'b1, 1'b1, 8'h21, 8'h22};
        vecs[4] = '{4'b1111, 4'b0100, 8'h50, 8'h51, 8'h52, 8'h53, 4'b0011, 1'b0, 1'b0, 1'b1, 1'b1, 8'h50, 8'h51};
        vecs[5] = '{4'b1100, 4'b0100, 8'h00, 8'h00, 8'h66, 8'h66, 4'b0100, 1'b0, 1'b1, 1'b0, 1'b1, 8'h66, 8'h00};
        vecs[6] = '{4'b0101, 4'b0000, 8'h77, 8'h00, 8'h77, 8'h00, 4'b0101, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 8'h77};
        vecs[7] = '{4'b1001, 4'b1001, 8'h88, 8'h00, 8'h00, 8'h89, 4'b1001, 1'b0, 1'b0, 1'b0, 1'b0, 8'h88, 8'h89};

        // Reset state, with all requests raised to show gnt is forced low
        rst = 1'b1;
        idle_inputs();
        req_i = 4'b1111;
        step();
        step();
        chk("rst_gnt", 64'(gnt_o), 64'h0);
        chk("rst_rvalid", 64'(rvalid_o), 64'h0);
        chk("rst_rdata", 64'(|rdata_o), 64'h0);
        chk("rst_cen", 64'({ram_cena_o, ram_cenb_o}), 64'h3);
        chk("rst_wen", 64'({ram_wena_o, ram_wenb_o}), 64'h3);
        chk("rst_oen", 64'({ram_oena_o, ram_oenb_o}), 64'h0);
        chk("rst_addr", 64'({ram_addra_o, ram_addrb_o}), 64'h0);
        chk("rst_data", 64'({ram_dataa_o, ram_datab_o}), 64'h0);
        $display("reset: gnt=%b cen=%b%b", gnt_o, ram_cena_o, ram_cenb_o);
        rst = 1'b0;
        idle_inputs();

        // Selection table, each vector from a fresh reset (ptr = 0)
        for (int v = 0; v < 8; v++) begin
            do_reset();
            req_i  = vecs[v].req;
            we_i   = vecs[v].we;
            addr_i = {vecs[v].a3, vecs[v].a2, vecs[v].a1, vecs[v].a0};
            wdata_i = {32'hC0DE0003, 32'hC0DE0002, 32'hC0DE0001, 32'hC0DE0000};
            #1;
            chk($sformatf("vec%0d_gnt", v), 64'(gnt_o), 64'(vecs[v].gnt));
            step();
            idle_inputs();
            chk($sformatf("vec%0d_cen", v), 64'({ram_cena_o, ram_cenb_o}), 64'({vecs[v].cena, vecs[v].cenb}));
            chk($sformatf("vec%0d_wen", v), 64'({ram_wena_o, ram_wenb_o}), 64'({vecs[v].wena, vecs[v].wenb}));
            chk($sformatf("vec%0d_addr", v), 64'({ram_addra_o, ram_addrb_o}), 64'({vecs[v].addra, vecs[v].addrb}));
            $display("vec %0d: req=%b we=%b gnt=%b cen=%b%b addr=%h/%h", v, vecs[v].req, vecs[v].we,
                     gnt_o, ram_cena_o, ram_cenb_o, ram_addra_o, ram_addrb_o);
        end

        // Single read: write 0xDEADBEEF to 0x10 via req 0, then req 2 reads it
        do_reset();
        req_i = 4'b0001; we_i = 4'b0001; addr_i = {24'h0, 8'h10}; wdata_i = {96'h0, 32'hDEADBEEF};
        #1;
        chk("sr_wr_gnt", 64'(gnt_o), 64'h1);
        step();
        chk("sr_wr_issue", 64'({ram_cena_o, ram_wena_o, ram_addra_o, ram_dataa_o}), {22'h0, 1'b0, 1'b0, 8'h10, 32'hDEADBEEF});
        idle_inputs();
        req_i = 4'b0100; addr_i = {8'h0, 8'h10, 16'h0};
        #1;
        chk("sr_rd_gnt", 64'(gnt_o), 64'h4);
        step();
        idle_inputs();
        chk("sr_rd_issue", 64'({ram_cena_o, ram_wena_o, ram_addra_o}), {54'h0, 1'b0, 1'b1, 8'h10});
        chk("sr_rvalid_t1", 64'(rvalid_o), 64'h0);
        step();
        chk("sr_rvalid", 64'(rvalid_o), 64'h4);
        chk("sr_rdata", 64'(rdata_o[64 +: 32]), 64'hDEADBEEF);
        $display("single read: rvalid=%b rdata2=%h", rvalid_o, rdata_o[64 +: 32]);
        step();
        chk("sr_rvalid_after", 64'(rvalid_o), 64'h0);

        // Dual issue: req 1 reads 0x03, req 3 writes 0x55 to 0x04
        do_reset();
        req_i = 4'b1010; we_i = 4'b1000; addr_i = {8'h04, 8'h00, 8'h03, 8'h00};
        wdata_i = {32'h55, 96'h0};
        #1;
        chk("dual_gnt", 64'(gnt_o), 64'hA);
        step();
        chk("dual_a", 64'({ram_cena_o, ram_wena_o, ram_addra_o}), {54'h0, 1'b0, 1'b1, 8'h03});
        chk("dual_b", 64'({ram_cenb_o, ram_wenb_o, ram_addrb_o, ram_datab_o}), {22'h0, 1'b0, 1'b0, 8'h04, 32'h55});
        // ptr back at 0: a full request set picks {0,1}
        req_i = 4'b1111; we_i = 4'b0000; addr_i = {8'h63, 8'h62, 8'h61, 8'h60};
        #1;
        chk("dual_ptr", 64'(gnt_o), 64'h3);
        step();
        idle_inputs();
        chk("dual_rvalid", 64'(rvalid_o), 64'h2);
        $display("dual issue: rvalid=%b", rvalid_o);

        // Conflict: req 0 writes 0x20, req 1 reads 0x20 in the same cycle
        do_reset();
        req_i = 4'b0011; we_i = 4'b0001; addr_i = {16'h0, 8'h20, 8'h20}; wdata_i = {96'h0, 32'hA5A5F00D};
        #1;
        chk("cf_gnt_t", 64'(gnt_o), 64'h1);
        step();
        req_i = 4'b0010; we_i = 4'b0000;
        #1;
        chk("cf_gnt_t1", 64'(gnt_o), 64'h2);
        chk("cf_wr_issue", 64'({ram_cena_o, ram_wena_o, ram_addra_o}), {54'h0, 1'b0, 1'b0, 8'h20});
        step();
        idle_inputs();
        chk("cf_rd_issue", 64'({ram_cena_o, ram_wena_o, ram_addra_o}), {54'h0, 1'b0, 1'b1, 8'h20});
        step();
        chk("cf_rvalid", 64'(rvalid_o), 64'h2);
        chk("cf_rdata", 64'(rdata_o[32 +: 32]), 64'hA5A5F00D);
        $display("conflict: rvalid=%b rdata1=%h", rvalid_o, rdata_o[32 +: 32]);

        // Fairness: all four requests held
`ifdef RAM_ARB_RR_EN
        fair_exp = '{4'b0011, 4'b1100, 4'b0011, 4'b1100, 4'b0011, 4'b1100};
`else
        fair_exp = '{4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011, 4'b0011};
`endif
        do_reset();
        req_i = 4'b1111; we_i = 4'b0000; addr_i = {8'h33, 8'h32, 8'h31, 8'h30};
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("fair_gnt%0d", c), 64'(gnt_o), 64'(fair_exp[c]));
            if (c >= 2) chk($sformatf("fair_rvalid%0d", c), 64'(rvalid_o), 64'(fair_exp[c-2]));
            $display("fair cycle %0d: gnt=%b rvalid=%b", c, gnt_o, rvalid_o);
            step();
        end
        idle_inputs();

        // Reset in the cycle after a read grant
        do_reset();
        req_i = 4'b0100; we_i = 4'b0000; addr_i = {8'h0, 8'h10, 16'h0};
        #1;
        chk("mr_gnt", 64'(gnt_o), 64'h4);
        step();
        chk("mr_issue", 64'(ram_cena_o), 64'h0);
        rst = 1'b1;
        req_i = 4'b1111;
        #1;
        chk("mr_gnt_rst", 64'(gnt_o), 64'h0);
        step();
        chk("mr_cen", 64'({ram_cena_o, ram_cenb_o, ram_wena_o, ram_wenb_o}), 64'hF);
        chk("mr_rvalid0", 64'(rvalid_o), 64'h0);
        chk("mr_gnt_held", 64'(gnt_o), 64'h0);
        step();
        chk("mr_rvalid1", 64'(rvalid_o), 64'h0);
        rst = 1'b0;
        idle_inputs();
        for (int c = 0; c < 3; c++) begin
            step();
            chk($sformatf("mr_rvalid_post%0d", c), 64'(rvalid_o), 64'h0);
        end
        $display("reset mid-read: rvalid=%b cen=%b%b", rvalid_o, ram_cena_o, ram_cenb_o);

        // Idle for 10 cycles
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("idle_cen%0d", c), 64'({ram_cena_o, ram_cenb_o}), 64'h3);
            chk($sformatf("idle_rvalid%0d", c), 64'(rvalid_o), 64'h0);
        end
        $display("idle: cen=%b%b rvalid=%b", ram_cena_o, ram_cenb_o, rvalid_o);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
